// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data path.
// Data is favoured; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              imem_valid,
   input  logic [XLEN-1:0]   imem_addr,
   output logic              imem_ready,
   output logic [XLEN-1:0]   imem_rdata,
   input  logic              dmem_valid,
   input  logic [XLEN-1:0]   dmem_addr,
   input  logic [XLEN-1:0]   dmem_wdata,
   input  logic [XLEN/8-1:0] dmem_wstrb,
   output logic              dmem_ready,
   output logic [XLEN-1:0]   dmem_rdata,
   output logic              mem_valid,
   output logic              mem_instr,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int SW = XLEN / 8;
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

   state_t          state_reg;
   logic            i_pend_reg, d_pend_reg, discard_reg, req_instr_reg;
   logic [XLEN-1:0] i_addr_reg, d_addr_reg, d_wdata_reg, req_addr_reg, req_wdata_reg;
   logic [SW-1:0]   d_wstrb_reg, req_wstrb_reg;
   logic [CW-1:0]   starve_reg, starve_next;

   logic            idle, i_done, d_done, i_acc, d_acc, i_cand, d_cand, starved;
   logic            grant_i, grant_d;
   logic [XLEN-1:0] i_cur_addr, d_cur_addr, d_cur_wdata;
   logic [SW-1:0]   d_cur_wstrb;

   // Pending flags stay set until the request completes, so they also mark "outstanding".
   assign idle    = rst && (state_reg == IDLE);
   assign i_done  = rst && (state_reg == BUSY_I) && mem_ready && !discard_reg && !flush;
   assign d_done  = rst && (state_reg == BUSY_D) && mem_ready;
   assign i_acc   = imem_valid && !flush && (!i_pend_reg || i_done);
   assign d_acc   = dmem_valid && (!d_pend_reg || d_done);
   assign i_cand  = idle && !flush && (i_pend_reg || i_acc);
   assign d_cand  = idle && (d_pend_reg || d_acc);
   assign starved = (starve_reg == CW'(STARVE_LIMIT));
   assign grant_i = i_cand && (!d_cand || starved);
   assign grant_d = d_cand && !grant_i;

   assign i_cur_addr  = i_pend_reg ? i_addr_reg  : imem_addr;
   assign d_cur_addr  = d_pend_reg ? d_addr_reg  : dmem_addr;
   assign d_cur_wdata = d_pend_reg ? d_wdata_reg : dmem_wdata;
   assign d_cur_wstrb = d_pend_reg ? d_wstrb_reg : dmem_wstrb;

   assign imem_ready = i_done;
   assign dmem_ready = d_done;
   assign mem_valid  = grant_i || grant_d;
   assign mem_instr  = grant_i || (!grant_d && req_instr_reg);

   for (genvar gi = 0; gi < XLEN; gi++) begin : g_rdata
      assign imem_rdata[gi] = mem_rdata[gi] & imem_ready;
      assign dmem_rdata[gi] = mem_rdata[gi] & dmem_ready;
   end

   always_comb begin
      mem_addr    = req_addr_reg;
      mem_wdata   = req_wdata_reg;
      mem_wstrb   = req_wstrb_reg;
      starve_next = starve_reg;
      if (grant_i) begin
         mem_addr    = i_cur_addr;
         mem_wdata   = '0;
         mem_wstrb   = '0;
         starve_next = '0;
      end else if (grant_d) begin
         mem_addr  = d_cur_addr;
         mem_wdata = d_cur_wdata;
         mem_wstrb = d_cur_wstrb;
         if (!i_cand)
            starve_next = '0;
         else if (!starved)
            starve_next = starve_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         i_pend_reg    <= 1'b0;
         d_pend_reg    <= 1'b0;
         discard_reg   <= 1'b0;
         req_instr_reg <= 1'b0;
         i_addr_reg    <= '0;
         d_addr_reg    <= '0;
         d_wdata_reg   <= '0;
         d_wstrb_reg   <= '0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
         req_wstrb_reg <= '0;
         starve_reg    <= '0;
      end else begin
         if (flush)
            i_pend_reg <= 1'b0;
         else if (i_acc)
            i_pend_reg <= 1'b1;
         else if (i_done)
            i_pend_reg <= 1'b0;
         if (i_acc)
            i_addr_reg <= imem_addr;

         if (d_acc) begin
            d_pend_reg  <= 1'b1;
            d_addr_reg  <= dmem_addr;
            d_wdata_reg <= dmem_wdata;
            d_wstrb_reg <= dmem_wstrb;
         end else if (d_done) begin
            d_pend_reg <= 1'b0;
         end

         starve_reg <= starve_next;

         case (state_reg)
            IDLE: begin
               if (grant_i || grant_d) begin
                  state_reg     <= grant_i ? BUSY_I : BUSY_D;
                  req_instr_reg <= grant_i;
                  req_addr_reg  <= mem_addr;
                  req_wdata_reg <= mem_wdata;
                  req_wstrb_reg <= mem_wstrb;
               end
            end
            BUSY_I: begin
               // A flushed fetch still owns the port; its response is swallowed on arrival.
               if (mem_ready) begin
                  state_reg   <= IDLE;
                  discard_reg <= 1'b0;
               end else if (flush) begin
                  discard_reg <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants/responses are queued at stimulus
// time and matched against what a negedge monitor records from the DUT.
module tb_mem_port_arbiter;
   localparam int XLEN = 32;
   localparam int SW   = XLEN / 8;
   localparam int LAT  = 3;

   logic            clk = 1'b0;
   logic            rst, flush;
   logic            imem_valid, imem_ready, dmem_valid, dmem_ready;
   logic [XLEN-1:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [SW-1:0]   dmem_wstrb, mem_wstrb;
   logic            mem_valid, mem_instr, mem_ready;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] cyc;
   } grant_t;
   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
      logic [31:0] cyc;
   } resp_t;

   grant_t exp_g[$], obs_g[$];
   resp_t  exp_r[$], obs_r[$];
   int checks = 0, failures = 0, zero_viol = 0, both_ready = 0;
   logic [31:0] cyc = '0;
   logic i_out = 1'b0, d_out = 1'b0;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h3C3C, 16'hBEEF};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: one entry per observed grant/response.
   always @(negedge clk) begin
      grant_t g;
      resp_t  r;
      if (mem_valid) begin
         g = '{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, cyc: cyc};
         obs_g.push_back(g);
      end
      if (imem_ready) begin
         r = '{is_d: 1'b0, data: imem_rdata, cyc: cyc};
         obs_r.push_back(r);
      end
      if (dmem_ready) begin
         r = '{is_d: 1'b1, data: dmem_rdata, cyc: cyc};
         obs_r.push_back(r);
      end
      if ((!imem_ready && imem_rdata != 0) || (!dmem_ready && dmem_rdata != 0)) zero_viol++;
      if (imem_ready && dmem_ready) both_ready++;
   end

   // Memory: answers LAT cycles after a request; junk on rdata when not answering.
   initial begin
      int rcnt;
      logic rst_at;
      logic [31:0] raddr;
      rcnt = 0;
      raddr = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_valid && rst) begin
            rcnt  = LAT;
            raddr = mem_addr;
         end
         @(posedge clk);
         rst_at = rst;
         #1;
         mem_ready = 1'b0;
         mem_rdata = $urandom;
         if (!rst_at) rcnt = 0;
         else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               mem_ready = 1'b1;
               mem_rdata = mem_model(raddr);
            end
         end
      end
   end

   // Requesters never pulse again while a request is outstanding.
   always @(posedge clk) begin
      if (!rst) begin
         i_out <= 1'b0;
         d_out <= 1'b0;
      end else begin
         assert (!(imem_valid && !flush && i_out)) else $error("imem pulse while outstanding");
         assert (!(dmem_valid && d_out)) else $error("dmem pulse while outstanding");
         if (imem_valid && !flush) i_out <= 1'b1;
         else if (imem_ready || flush) i_out <= 1'b0;
         if (dmem_valid) d_out <= 1'b1;
         else if (dmem_ready) d_out <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic drive_i(input logic [31:0] a);
      imem_valid = 1'b1;
      imem_addr  = a;
   endtask

   task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      dmem_valid = 1'b1;
      dmem_addr  = a;
      dmem_wdata = wd;
      dmem_wstrb = ws;
   endtask

   task automatic push_g(input logic instr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] c);
      grant_t g;
      g = '{instr: instr, addr: a, wdata: wd, wstrb: ws, cyc: c};
      exp_g.push_back(g);
   endtask

   task automatic push_r(input logic is_d, input logic [31:0] d, input logic [31:0] c);
      resp_t r;
      r = '{is_d: is_d, data: d, cyc: c};
      exp_r.push_back(r);
   endtask

   // Waits (bounded) until as many events were seen as expected, then lets stragglers show up.
   task automatic settle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (obs_g.size() >= exp_g.size() && obs_r.size() >= exp_r.size()) break;
         tick();
      end
      repeat (6) tick();
   endtask

   task automatic clear_queues();
      exp_g.delete(); obs_g.delete(); exp_r.delete(); obs_r.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_ready, imem_rdata,
           dmem_ready, dmem_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%0b instr=%0b addr=%h wdata=%h wstrb=%b want all 0",
                  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb);
      end
      checks++;
      if ({dut.starve_reg, dut.i_pend_reg, dut.d_pend_reg, dut.discard_reg} !== '0) begin
         failures++;
         $display("FAIL reset_state got starve=%0d ipend=%0b dpend=%0b discard=%0b want 0",
                  dut.starve_reg, dut.i_pend_reg, dut.d_pend_reg, dut.discard_reg);
      end
      tick();
      rst = 1'b1;
      tick();
      clear_queues();
      $display("txn reset done");
   endtask

   task automatic test_single_fetch();
      grant_t go, ge;
      resp_t ro, re;
      logic [31:0] c0;
      tick();
      c0 = cyc;
      drive_i(32'h100);
      push_g(1'b1, 32'h100, '0, '0, c0);
      push_r(1'b0, 32'hDEADBEEF, c0 + LAT);
      settle(30);
      checks++;
      if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
         failures++;
         $display("FAIL single_fetch_count got grants=%0d resps=%0d want %0d/%0d",
                  obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
      end
      while (obs_g.size() > 0 && exp_g.size() > 0) begin
         go = obs_g.pop_front(); ge = exp_g.pop_front(); checks++;
         if (go !== ge) begin failures++; $display("FAIL single_fetch_grant got %h want %h", go, ge); end
         else $display("txn single_fetch grant instr=%0b addr=%h cyc=%0d", go.instr, go.addr, go.cyc);
      end
      while (obs_r.size() > 0 && exp_r.size() > 0) begin
         ro = obs_r.pop_front(); re = exp_r.pop_front(); checks++;
         if (ro !== re) begin failures++; $display("FAIL single_fetch_resp got %h want %h", ro, re); end
         else $display("txn single_fetch resp d=%0b data=%h cyc=%0d", ro.is_d, ro.data, ro.cyc);
      end
      clear_queues();
   endtask

   task automatic test_data_priority();
      grant_t go, ge;
      resp_t ro, re;
      logic [31:0] c0;
      tick();
      c0 = cyc;
      drive_i(32'h200);
      drive_d(32'h8000, '0, '0);
      push_g(1'b0, 32'h8000, '0, '0, c0);
      push_g(1'b1, 32'h200, '0, '0, c0 + LAT + 1);
      push_r(1'b1, mem_model(32'h8000), c0 + LAT);
      push_r(1'b0, mem_model(32'h200), c0 + 2 * LAT + 1);
      settle(40);
      checks++;
      if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
         failures++;
         $display("FAIL priority_count got grants=%0d resps=%0d want %0d/%0d",
                  obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
      end
      while (obs_g.size() > 0 && exp_g.size() > 0) begin
         go = obs_g.pop_front(); ge = exp_g.pop_front(); checks++;
         if (go !== ge) begin failures++; $display("FAIL priority_grant got %h want %h", go, ge); end
         else $display("txn priority grant instr=%0b addr=%h cyc=%0d", go.instr, go.addr, go.cyc);
      end
      while (obs_r.size() > 0 && exp_r.size() > 0) begin
         ro = obs_r.pop_front(); re = exp_r.pop_front(); checks++;
         if (ro !== re) begin failures++; $display("FAIL priority_resp got %h want %h", ro, re); end
         else $display("txn priority resp d=%0b data=%h cyc=%0d", ro.is_d, ro.data, ro.cyc);
      end
      checks++;
      if (both_ready !== 0) begin
         failures++;
         $display("FAIL ready_overlap got %0d coincident cycles want 0", both_ready);
      end
      clear_queues();
   endtask

   task automatic test_starvation();
      grant_t go, ge;
      resp_t ro, re;
      logic [31:0] c0;
      tick();
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         push_g(1'b0, 32'hA000 + 32'(4 * k), '0, '0, c0 + 32'(4 * k));
         push_r(1'b1, mem_model(32'hA000 + 32'(4 * k)), c0 + 32'(4 * k) + LAT);
      end
      push_g(1'b1, 32'h400, '0, '0, c0 + 16);
      push_r(1'b0, mem_model(32'h400), c0 + 16 + LAT);
      push_g(1'b0, 32'hA010, '0, '0, c0 + 20);
      push_r(1'b1, mem_model(32'hA010), c0 + 20 + LAT);
      drive_i(32'h400);
      for (int k = 0; k < 5; k++) begin
         drive_d(32'hA000 + 32'(4 * k), '0, '0);
         if (k < 4) repeat (4) tick();
      end
      tick();
      checks++;
      if (dut.starve_reg !== '0) begin
         failures++;
         $display("FAIL starve_after_fetch got %0d want 0", dut.starve_reg);
      end
      settle(60);
      checks++;
      if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
         failures++;
         $display("FAIL starve_count got grants=%0d resps=%0d want %0d/%0d",
                  obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
      end
      while (obs_g.size() > 0 && exp_g.size() > 0) begin
         go = obs_g.pop_front(); ge = exp_g.pop_front(); checks++;
         if (go !== ge) begin failures++; $display("FAIL starve_grant got %h want %h", go, ge); end
         else $display("txn starve grant instr=%0b addr=%h cyc=%0d", go.instr, go.addr, go.cyc);
      end
      while (obs_r.size() > 0 && exp_r.size() > 0) begin
         ro = obs_r.pop_front(); re = exp_r.pop_front(); checks++;
         if (ro !== re) begin failures++; $display("FAIL starve_resp got %h want %h", ro, re); end
         else $display("txn starve resp d=%0b data=%h cyc=%0d", ro.is_d, ro.data, ro.cyc);
      end
      clear_queues();
   endtask

   task automatic test_store();
      grant_t go, ge;
      resp_t ro, re;
      logic [31:0] c0;
      tick();
      c0 = cyc;
      drive_d(32'h10, 32'h55AA, 4'b0011);
      push_g(1'b0, 32'h10, 32'h55AA, 4'b0011, c0);
      push_r(1'b1, mem_model(32'h10), c0 + LAT);
      push_g(1'b1, 32'h500, '0, '0, c0 + LAT + 1);
      push_r(1'b0, mem_model(32'h500), c0 + 2 * LAT + 1);
      tick();
      drive_i(32'h500);
      settle(40);
      checks++;
      if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
         failures++;
         $display("FAIL store_count got grants=%0d resps=%0d want %0d/%0d",
                  obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
      end
      while (obs_g.size() > 0 && exp_g.size() > 0) begin
         go = obs_g.pop_front(); ge = exp_g.pop_front(); checks++;
         if (go !== ge) begin failures++; $display("FAIL store_grant got %h want %h", go, ge); end
         else $display("txn store grant instr=%0b addr=%h wdata=%h wstrb=%b cyc=%0d",
                       go.instr, go.addr, go.wdata, go.wstrb, go.cyc);
      end
      while (obs_r.size() > 0 && exp_r.size() > 0) begin
         ro = obs_r.pop_front(); re = exp_r.pop_front(); checks++;
         if (ro !== re) begin failures++; $display("FAIL store_resp got %h want %h", ro, re); end
         else $display("txn store resp d=%0b data=%h cyc=%0d", ro.is_d, ro.data, ro.cyc);
      end
      clear_queues();
   endtask

   task automatic test_flush();
      grant_t go, ge;
      resp_t ro, re;
      logic [31:0] c0, c1;
      // Flush while a fetch is in flight, then a fresh fetch right after the flush.
      tick();
      c0 = cyc;
      drive_i(32'h280);
      push_g(1'b1, 32'h280, '0, '0, c0);
      push_g(1'b1, 32'h300, '0, '0, c0 + LAT + 1);
      push_r(1'b0, mem_model(32'h300), c0 + 2 * LAT + 1);
      tick();
      flush = 1'b1;
      tick();
      drive_i(32'h300);
      repeat (10) tick();
      // Flush in the cycle after a lost arbitration: pending fetch dropped, data kept.
      c1 = cyc;
      drive_d(32'h600, '0, '0);
      drive_i(32'h700);
      push_g(1'b0, 32'h600, '0, '0, c1);
      push_r(1'b1, mem_model(32'h600), c1 + LAT);
      tick();
      flush = 1'b1;
      settle(40);
      checks++;
      if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
         failures++;
         $display("FAIL flush_count got grants=%0d resps=%0d want %0d/%0d",
                  obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
      end
      while (obs_g.size() > 0 && exp_g.size() > 0) begin
         go = obs_g.pop_front(); ge = exp_g.pop_front(); checks++;
         if (go !== ge) begin failures++; $display("FAIL flush_grant got %h want %h", go, ge); end
         else $display("txn flush grant instr=%0b addr=%h cyc=%0d", go.instr, go.addr, go.cyc);
      end
      while (obs_r.size() > 0 && exp_r.size() > 0) begin
         ro = obs_r.pop_front(); re = exp_r.pop_front(); checks++;
         if (ro !== re) begin failures++; $display("FAIL flush_resp got %h want %h", ro, re); end
         else $display("txn flush resp d=%0b data=%h cyc=%0d", ro.is_d, ro.data, ro.cyc);
      end
      clear_queues();
   endtask

   task automatic test_reset_busy();
      grant_t go, ge;
      resp_t ro, re;
      logic [31:0] c0, c1;
      tick();
      c0 = cyc;
      drive_i(32'hB00);
      drive_d(32'h9000, '0, '0);
      push_g(1'b0, 32'h9000, '0, '0, c0);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_ready, imem_rdata,
           dmem_ready, dmem_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_busy_outputs got valid=%0b instr=%0b addr=%h dready=%0b want all 0",
                  mem_valid, mem_instr, mem_addr, dmem_ready);
      end
      checks++;
      if ({dut.starve_reg, dut.i_pend_reg, dut.d_pend_reg} !== '0) begin
         failures++;
         $display("FAIL reset_busy_state got starve=%0d ipend=%0b dpend=%0b want 0",
                  dut.starve_reg, dut.i_pend_reg, dut.d_pend_reg);
      end
      tick();
      c1 = cyc;
      drive_d(32'h9100, '0, '0);
      push_g(1'b0, 32'h9100, '0, '0, c1);
      push_r(1'b1, mem_model(32'h9100), c1 + LAT);
      settle(40);
      checks++;
      if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
         failures++;
         $display("FAIL reset_busy_count got grants=%0d resps=%0d want %0d/%0d",
                  obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
      end
      while (obs_g.size() > 0 && exp_g.size() > 0) begin
         go = obs_g.pop_front(); ge = exp_g.pop_front(); checks++;
         if (go !== ge) begin failures++; $display("FAIL reset_busy_grant got %h want %h", go, ge); end
         else $display("txn reset_busy grant instr=%0b addr=%h cyc=%0d", go.instr, go.addr, go.cyc);
      end
      while (obs_r.size() > 0 && exp_r.size() > 0) begin
         ro = obs_r.pop_front(); re = exp_r.pop_front(); checks++;
         if (ro !== re) begin failures++; $display("FAIL reset_busy_resp got %h want %h", ro, re); end
         else $display("txn reset_busy resp d=%0b data=%h cyc=%0d", ro.is_d, ro.data, ro.cyc);
      end
      clear_queues();
   endtask

   task automatic test_rdata_gating();
      checks++;
      if (zero_viol !== 0) begin
         failures++;
         $display("FAIL rdata_gating got %0d cycles with nonzero rdata while not ready want 0", zero_viol);
      end
      checks++;
      if (both_ready !== 0) begin
         failures++;
         $display("FAIL ready_overlap_total got %0d want 0", both_ready);
      end
      $display("txn rdata_gating checked");
   endtask

   initial begin
      rst        = 1'b0;
      flush      = 1'b0;
      imem_valid = 1'b0;
      imem_addr  = '0;
      dmem_valid = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_wstrb = '0;
      test_reset();
      test_single_fetch();
      test_data_priority();
      test_starvation();
      test_store();
      test_flush();
      test_reset_busy();
      test_rdata_gating();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
